// File: rtl/serializer_multilane.sv
// serializer_multilane
// Parallel-to-serial converter. DATA_W-bit words arrive on a valid/ready
// handshake and leave as BEATS = DATA_W/LANES beats of LANES bits each on a
// second valid/ready handshake. A one-word holding buffer lets the next word
// wait while the current one shifts out, so words stream back to back.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          clock enable; 0 freezes every register
//   iv_din        input word
//   i_din_valid   input word valid
//   o_din_ready   a word can be accepted (hold buffer empty)
//   ov_dout       current output beat
//   o_dout_valid  ov_dout valid
//   i_dout_ready  downstream takes the beat
//   o_last        current beat is the final beat of its word
//   o_busy        shifting or holding a word
//
// state   | meaning
// S_IDLE  | nothing in flight, sreg cleared, output invalid
// S_SHIFT | sreg holds the word being emitted, cnt = beat index

module serializer_multilane #(
    parameter int DATA_W    = 24,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_din_ready,
    output logic [LANES-1:0]  ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_last,
    output logic              o_busy
);

    localparam int BEATS = DATA_W / LANES;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    if ((DATA_W % LANES) != 0) begin : g_bad_lanes
        $error("serializer_multilane: LANES must divide DATA_W");
    end

    logic [0:0]        state;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shifted;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hold;
    logic              hold_valid;

    logic accept;
    logic xfer;
    logic last_beat;
    logic bypass;

    // The lane group that leaves next sits at the end of sreg that is shifted
    // out; zero fill keeps ov_dout at 0 once the word is gone.
    if (MSB_FIRST) begin : g_msb
        assign sreg_shifted = sreg << LANES;
        assign ov_dout      = sreg[DATA_W-1 -: LANES];
    end else begin : g_lsb
        assign sreg_shifted = sreg >> LANES;
        assign ov_dout      = sreg[LANES-1:0];
    end

    assign o_dout_valid = (state == S_SHIFT);
    assign o_din_ready  = ~hold_valid;
    assign o_busy       = o_dout_valid | hold_valid;

    assign last_beat = (cnt == LAST_CNT);
    assign o_last    = o_dout_valid & last_beat;

    assign accept = i_en & i_din_valid & ~hold_valid;
    assign xfer   = i_en & o_dout_valid & i_dout_ready;
    // A word arriving exactly as the last beat leaves (with hold empty) goes
    // straight into sreg instead of passing through hold.
    assign bypass = xfer & last_beat & accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (i_en) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sreg  <= iv_din;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        if (!last_beat) begin
                            sreg <= sreg_shifted;
                            cnt  <= cnt + 1'b1;
                        end else if (hold_valid) begin
                            sreg       <= hold;
                            cnt        <= '0;
                            hold_valid <= 1'b0;
                        end else if (accept) begin
                            sreg <= iv_din;
                            cnt  <= '0;
                        end else begin
                            sreg  <= '0;
                            cnt   <= '0;
                            state <= S_IDLE;
                        end
                    end
                    // accept implies hold is empty, so this never collides
                    // with the drain above.
                    if (accept && !bypass) begin
                        hold       <= iv_din;
                        hold_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_multilane.sv
module tb_serializer_multilane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] din;
    logic        din_valid;
    logic        dready;

    logic        s1_ready, s1_valid, s1_last, s1_busy;
    logic [0:0]  s1_dout;
    logic        m4_ready, m4_valid, m4_last, m4_busy;
    logic [3:0]  m4_dout;

    always #5 clk = ~clk;

    serializer_multilane #(.DATA_W(24), .LANES(1), .MSB_FIRST(1'b0)) u_s1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_din_ready  (s1_ready),
        .ov_dout      (s1_dout),
        .o_dout_valid (s1_valid),
        .i_dout_ready (dready),
        .o_last       (s1_last),
        .o_busy       (s1_busy)
    );

    serializer_multilane #(.DATA_W(24), .LANES(4), .MSB_FIRST(1'b1)) u_m4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_din_ready  (m4_ready),
        .ov_dout      (m4_dout),
        .o_dout_valid (m4_valid),
        .i_dout_ready (dready),
        .o_last       (m4_last),
        .o_busy       (m4_busy)
    );

    // index 0 = LANES=1 LSB-first, index 1 = LANES=4 MSB-first
    logic [3:0] ob_dout [2];
    logic       ob_valid[2];
    logic       ob_last [2];
    logic       ob_ready[2];
    logic       ob_busy [2];

    always_comb begin
        ob_dout[0]  = {3'b000, s1_dout};
        ob_dout[1]  = m4_dout;
        ob_valid[0] = s1_valid;
        ob_valid[1] = m4_valid;
        ob_last[0]  = s1_last;
        ob_last[1]  = m4_last;
        ob_ready[0] = s1_ready;
        ob_ready[1] = m4_ready;
        ob_busy[0]  = s1_busy;
        ob_busy[1]  = m4_busy;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: up to two words in flight per instance (one being
    // emitted, one waiting) and the index of the next beat of the front word.
    logic [23:0] mq[2][2];
    int          mn[2];
    int          mk[2];

    // Beats actually transferred by the DUTs, for content checks.
    logic [3:0]  lg [2][64];
    logic        lgl[2][64];
    int          nlg[2];
    int          nval[2];

    function automatic int nbeats(input int i);
        return (i == 0) ? 24 : 6;
    endfunction

    function automatic logic [3:0] beat_val(input int i, input logic [23:0] w, input int k);
        if (i == 0) return {3'b000, w[k]};
        return 4'((w >> (20 - 4 * k)) & 24'hF);
    endfunction

    function automatic string tagi(input string t, input int i);
        return $sformatf("%s_%s", t, (i == 0) ? "s1" : "m4");
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, log DUT
    // transfers, then advance the model by what the coming edge will do.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic       mv;
            logic [3:0] eb;
            logic       acc;
            logic       xf;
            mv = (mn[i] > 0);
            eb = mv ? beat_val(i, mq[i][0], mk[i]) : 4'd0;
            chk(tagi("valid", i), ob_valid[i], mv);
            chk(tagi("dout", i), ob_dout[i], eb);
            chk(tagi("last", i), ob_last[i], mv && (mk[i] == nbeats(i) - 1));
            chk(tagi("din_ready", i), ob_ready[i], mn[i] < 2);
            chk(tagi("busy", i), ob_busy[i], mv);
            if (en && ob_valid[i] && dready && nlg[i] < 64) begin
                lg[i][nlg[i]]  = ob_dout[i];
                lgl[i][nlg[i]] = ob_last[i];
                nlg[i]++;
            end
            if (ob_valid[i]) nval[i]++;
            acc = en && din_valid && (mn[i] < 2);
            xf  = en && mv && dready;
            if (xf) begin
                mk[i]++;
                if (mk[i] == nbeats(i)) begin
                    mq[i][0] = mq[i][1];
                    mn[i]--;
                    mk[i] = 0;
                end
            end
            if (acc) begin
                mq[i][mn[i]] = din;
                mn[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [23:0] w);
        din       = w;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
    endtask

    task automatic clr_log();
        for (int i = 0; i < 2; i++) begin
            nlg[i]  = 0;
            nval[i] = 0;
        end
    endtask

    task automatic drain();
        din_valid = 1'b0;
        dready    = 1'b1;
        en        = 1'b1;
        for (int c = 0; c < 80 && (mn[0] > 0 || mn[1] > 0); c++) cycle();
        cycle();
        chk("drain_busy_s1", s1_busy, 1'b0);
        chk("drain_busy_m4", m4_busy, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        din_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(tagi("rst_dout", i), ob_dout[i], 4'd0);
            chk(tagi("rst_valid", i), ob_valid[i], 1'b0);
            chk(tagi("rst_last", i), ob_last[i], 1'b0);
            chk(tagi("rst_ready", i), ob_ready[i], 1'b1);
            chk(tagi("rst_busy", i), ob_busy[i], 1'b0);
            mn[i] = 0;
            mk[i] = 0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] p;
        int          nl;
        int          li;
        int          sum;

        rst_n     = 1'b0;
        en        = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        dready    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0;
            mk[i] = 0;
        end
        clr_log();

        // Reset state
        do_reset();
        cycle();
        cycle();

        // LSB-first serial of A5C3F0 (and the same word nibble-wise MSB-first)
        clr_log();
        put(24'hA5C3F0);
        drain();
        p = '0;
        nl = 0;
        li = -1;
        for (int k = 0; k < 24; k++) begin
            p[k] = lg[0][k][0];
            if (lgl[0][k]) begin
                nl++;
                li = k;
            end
        end
        chk("s1_a5c3f0_bits", p, 24'hA5C3F0);
        chk("s1_a5c3f0_nbeats", nlg[0], 24);
        chk("s1_a5c3f0_last_count", nl, 1);
        chk("s1_a5c3f0_last_pos", li, 23);
        p = '0;
        for (int k = 0; k < 6; k++) p = (p << 4) | 24'(lg[1][k]);
        chk("m4_a5c3f0_nibbles", p, 24'hA5C3F0);

        // MSB-first lanes: 123456 -> 1,2,3,4,5,6
        clr_log();
        put(24'h123456);
        drain();
        chk("m4_123456_nbeats", nlg[1], 6);
        nl = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("m4_123456_beat%0d", k), lg[1][k], k + 1);
            if (lgl[1][k]) nl++;
        end
        chk("m4_123456_last_on_6", lgl[1][5], 1'b1);
        chk("m4_123456_last_count", nl, 1);
        p = '0;
        for (int k = 0; k < 24; k++) p[k] = lg[0][k][0];
        chk("s1_123456_bits", p, 24'h123456);

        // Back-to-back: 000001 then 800000 held on the input
        clr_log();
        din       = 24'h000001;
        din_valid = 1'b1;
        cycle();
        din       = 24'h800000;
        cycle();
        drain();
        sum = 0;
        for (int k = 0; k < 48; k++) sum += int'(lg[0][k]);
        chk("b2b_s1_nbeats", nlg[0], 48);
        chk("b2b_s1_valid_cycles", nval[0], 48);
        chk("b2b_s1_first", lg[0][0], 4'd1);
        chk("b2b_s1_beat48", lg[0][47], 4'd1);
        chk("b2b_s1_ones", sum, 2);
        chk("b2b_m4_valid_cycles", nval[1], 12);
        chk("b2b_m4_beat6", lg[1][5], 4'd1);
        chk("b2b_m4_beat7", lg[1][6], 4'd8);

        // Backpressure and clock-enable gap mid-word
        clr_log();
        dready = 1'b0;
        put(24'h123456);
        for (int c = 0; c < 30; c++) begin
            dready = c[0];
            en     = !(c >= 4 && c < 9);
            cycle();
        end
        drain();
        chk("bp_m4_nbeats", nlg[1], 6);
        for (int k = 0; k < 6; k++) chk($sformatf("bp_m4_beat%0d", k), lg[1][k], k + 1);
        p = '0;
        for (int k = 0; k < 24; k++) p[k] = lg[0][k][0];
        chk("bp_s1_bits", p, 24'h123456);
        chk("bp_s1_nbeats", nlg[0], 24);

        // Reset mid-word with a second word held
        dready = 1'b1;
        put(24'hFFFFFF);
        put(24'hABCDEF);
        cycle();
        do_reset();
        clr_log();
        for (int c = 0; c < 6; c++) cycle();
        chk("post_rst_s1_beats", nlg[0], 0);
        chk("post_rst_m4_beats", nlg[1], 0);
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            din       = 24'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            dready    = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
